rst_req_ctrl: RTL

RST_REQ_CTRL -- requirements
Module: rst_req_ctrl

---
 rtl/rst_req_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rst_req_ctrl.sv
// rst_req_ctrl: collects per-source level reset requests and turns the rising
// edge of any enabled request into a fixed-length reset-request pulse,
// followed by a quiet hold-off window.
//
// Ports:
//   ref_clk_i   - single clock, all state on posedge
//   srst_i      - synchronous active-high reset
//   req_i       - per-source level reset requests (NUM_SRC bits)
//   en_i        - per-source enable mask, 0 ignores the source
//   cause_clr_i - clears the sticky cause record
//   arst_req_o  - reset request to the downstream arst_no generator
//   busy_o      - high while a request sequence is running
//   done_o      - one-cycle pulse at the end of each sequence
//   cause_o     - sticky record of the sources that triggered
module rst_req_ctrl #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned ASSERT_CYCLES  = 16,
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic               ref_clk_i,
  input  logic               srst_i,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] en_i,
  input  logic               cause_clr_i,
  output logic               arst_req_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [NUM_SRC-1:0] cause_o
);

  localparam int unsigned MAX_CYCLES =
    (ASSERT_CYCLES > HOLDOFF_CYCLES) ? ASSERT_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;

  // Counter holds "cycles remaining minus one", so zero marks the last cycle.
  localparam logic [CW-1:0] A_LOAD = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] H_LOAD = CW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [NUM_SRC-1:0]  req_q, req_d;
  logic [NUM_SRC-1:0]  cause_q, cause_d;
  logic                arst_q, arst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NUM_SRC-1:0]  trig;
  logic                trig_any;

  always_comb begin
    trig     = req_i & ~req_q & en_i;
    trig_any = |trig;

    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    req_d    = req_i;
    // Set wins over clear: clear first, then OR in this cycle's triggers.
    cause_d  = (cause_clr_i ? '0 : cause_q) | trig;

    unique case (state_q)
      IDLE: begin
        if (trig_any) begin
          state_d = ASSERT;
          cnt_d   = A_LOAD;
        end
      end
      ASSERT: begin
        // Triggers here are absorbed; only cause_d records them.
        if (cnt_q == '0) begin
          state_d = HOLDOFF;
          cnt_d   = H_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          // A trigger on the final hold-off cycle is treated as pending.
          if (pend_q || trig_any) begin
            state_d = ASSERT;
            cnt_d   = A_LOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (trig_any) begin
            pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase

    arst_d = (state_d == ASSERT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ref_clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      req_q   <= '0;
      cause_q <= '0;
      arst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      cause_q <= cause_d;
      arst_q  <= arst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign arst_req_o = arst_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cause_o    = cause_q;

endmodule
